// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array edge stages: default widths and
// a saturating clamp used when narrowing wide intermediate results.
package sa_pkg;

    localparam int SA_DATA_WIDTH = 32;
    localparam int SA_SHIFT_W    = 5;
    localparam int SA_WIDE_W     = 64;

    typedef logic signed [SA_WIDE_W-1:0] sa_wide_t;

    // Clamp v to the signed range of a w-bit integer; caller keeps the low w bits.
    function automatic sa_wide_t sa_saturate(input sa_wide_t v, input int w);
        sa_wide_t hi;
        sa_wide_t lo;
        hi = (sa_wide_t'(1) <<< (w - 1)) - sa_wide_t'(1);
        lo = -hi - sa_wide_t'(1);
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/sa_col_drain_if.sv
// Output handshake of the column drain toward the write-back path.
interface sa_col_drain_if #(
    parameter int OUT_WIDTH = 32
);
    logic                        DR_out_vld;
    logic                        DR_out_rdy;
    logic signed [OUT_WIDTH-1:0] DR_out_data;

    modport master (output DR_out_vld, output DR_out_data, input DR_out_rdy);
    modport slave  (input DR_out_vld, input DR_out_data, output DR_out_rdy);
endinterface

// File: rtl/sa_drain_fifo.sv
// First-word-fall-through FIFO; pointers carry one extra wrap bit so full and
// empty are distinguishable without a separate counter.
module sa_drain_fifo #(
    parameter int DEPTH     = 8,
    parameter int OUT_WIDTH = 32,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [OUT_WIDTH-1:0] din,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 full,
    output logic                 empty,
    output logic [AW:0]          level
);

    logic [OUT_WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        wr_en;
    logic        rd_en;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;

    // A pop frees the head slot in the same cycle, so a full FIFO still accepts.
    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;

    assign dout = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q[AW-1:0]] <= din;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/sa_col_drain.sv
// Column result drain: captures bottom-PE results, requantises them, queues
// them in a FWFT FIFO and tracks frame completion, overflow and mode collisions.
module sa_col_drain
    import sa_pkg::*;
#(
    parameter int DATA_WIDTH = SA_DATA_WIDTH,
    parameter int OUT_WIDTH  = 32,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         DR_clk,
    input  logic                         DR_rst,
    input  logic                         DR_clr,
    input  logic [SA_SHIFT_W-1:0]        DR_cfg_shift,
    input  logic                         DR_cfg_relu,
    input  logic [CNT_WIDTH-1:0]         DR_cfg_num,
    input  logic                         DR_calc_en,
    input  logic                         DR_store_en,
    input  logic signed [DATA_WIDTH-1:0] DR_data,
    sa_col_drain_if.master               dr_out,
    output logic [$clog2(DEPTH+1)-1:0]   DR_level,
    output logic                         DR_busy,
    output logic                         DR_done,
    output logic                         DR_ovf,
    output logic                         DR_err
);

    logic                 srst;
    logic                 calc_q, calc_d;
    logic                 ovf_q, ovf_d;
    logic                 err_q, err_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 pop;
    logic                 full;
    logic                 empty;
    sa_wide_t             shifted;
    sa_wide_t             clamped;
    logic [OUT_WIDTH-1:0] quant;
    logic                 unused_hi;

    assign srst = DR_rst | DR_clr;

    always_comb begin
        shifted = $signed({{(SA_WIDE_W-DATA_WIDTH){DR_data[DATA_WIDTH-1]}}, DR_data}) >>> DR_cfg_shift;
        if (DR_cfg_relu && (shifted < 0)) shifted = '0;
        clamped = sa_saturate(shifted, OUT_WIDTH);
    end

    assign quant     = clamped[OUT_WIDTH-1:0];
    assign unused_hi = ^clamped[SA_WIDE_W-1:OUT_WIDTH];

    assign dr_out.DR_out_vld = ~empty;
    assign pop               = dr_out.DR_out_vld & dr_out.DR_out_rdy;

    // calc_q marks the cycle in which the bottom PE's registered result is on DR_data.
    sa_drain_fifo #(
        .DEPTH     (DEPTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_fifo (
        .clk   (DR_clk),
        .srst  (srst),
        .push  (calc_q),
        .pop   (pop),
        .din   (quant),
        .dout  (dr_out.DR_out_data),
        .full  (full),
        .empty (empty),
        .level (DR_level)
    );

    assign cnt_inc = cnt_q + CNT_WIDTH'(1);

    always_comb begin
        calc_d  = DR_calc_en;
        ovf_d   = ovf_q | (calc_q & full & ~pop);
        err_d   = err_q | (calc_q & DR_store_en);
        cnt_d   = cnt_q;
        DR_done = 1'b0;
        if (pop) begin
            if ((DR_cfg_num != '0) && (cnt_inc == DR_cfg_num)) begin
                cnt_d   = '0;
                DR_done = 1'b1;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge DR_clk) begin
        if (srst) begin
            calc_q <= 1'b0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            calc_q <= calc_d;
            ovf_q  <= ovf_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    assign DR_ovf  = ovf_q;
    assign DR_err  = err_q;
    assign DR_busy = calc_q | (DR_level != '0) | (cnt_q != '0);

endmodule

// File: tb/tb_sa_col_drain.sv
// Directed bench for sa_col_drain with a 16-bit output: requantisation table,
// then overflow, full-with-pop, frame-done, collision and clear sequences.
module tb_sa_col_drain;
    import sa_pkg::*;

    localparam int DW    = 32;
    localparam int OW    = 16;
    localparam int DEPTH = 8;
    localparam int CW    = 16;

    logic                 DR_clk = 1'b0;
    logic                 DR_rst;
    logic                 DR_clr;
    logic [SA_SHIFT_W-1:0] DR_cfg_shift;
    logic                 DR_cfg_relu;
    logic [CW-1:0]        DR_cfg_num;
    logic                 DR_calc_en;
    logic                 DR_store_en;
    logic signed [DW-1:0] DR_data;
    logic [$clog2(DEPTH+1)-1:0] DR_level;
    logic                 DR_busy;
    logic                 DR_done;
    logic                 DR_ovf;
    logic                 DR_err;

    sa_col_drain_if #(.OUT_WIDTH(OW)) dr_if ();

    sa_col_drain #(
        .DATA_WIDTH (DW),
        .OUT_WIDTH  (OW),
        .DEPTH      (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .DR_clk       (DR_clk),
        .DR_rst       (DR_rst),
        .DR_clr       (DR_clr),
        .DR_cfg_shift (DR_cfg_shift),
        .DR_cfg_relu  (DR_cfg_relu),
        .DR_cfg_num   (DR_cfg_num),
        .DR_calc_en   (DR_calc_en),
        .DR_store_en  (DR_store_en),
        .DR_data      (DR_data),
        .dr_out       (dr_if),
        .DR_level     (DR_level),
        .DR_busy      (DR_busy),
        .DR_done      (DR_done),
        .DR_ovf       (DR_ovf),
        .DR_err       (DR_err)
    );

    always #5 DR_clk = ~DR_clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  shift;
        logic        relu;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge DR_clk);
        #1;
    endtask

    // Calc enable in one cycle, the result on DR_data in the next.
    task automatic send(input logic [31:0] d, input logic st);
        DR_calc_en = 1'b1;
        tick();
        DR_calc_en  = 1'b0;
        DR_data     = d;
        DR_store_en = st;
        tick();
        DR_data     = '0;
        DR_store_en = 1'b0;
    endtask

    // n back-to-back results first, first+1, ... with data trailing calc by a cycle.
    task automatic burst(input int n, input int first);
        for (int i = 0; i <= n; i++) begin
            DR_calc_en = (i < n);
            DR_data    = (i > 0) ? DW'(first + i - 1) : '0;
            tick();
        end
        DR_data = '0;
    endtask

    task automatic do_clear();
        DR_clr = 1'b1;
        tick();
        DR_clr = 1'b0;
    endtask

    initial begin
        DR_rst       = 1'b1;
        DR_clr       = 1'b0;
        DR_cfg_shift = '0;
        DR_cfg_relu  = 1'b0;
        DR_cfg_num   = '0;
        DR_calc_en   = 1'b0;
        DR_store_en  = 1'b0;
        DR_data      = '0;
        dr_if.DR_out_rdy = 1'b0;

        vecs[0]  = '{32'h0000_1230, 5'd4,  1'b0, 16'h0123};
        vecs[1]  = '{32'h7FFF_FFFF, 5'd0,  1'b0, 16'h7FFF};
        vecs[2]  = '{32'h8000_0000, 5'd0,  1'b0, 16'h8000};
        vecs[3]  = '{32'hFFFF_FFFB, 5'd0,  1'b1, 16'h0000};
        vecs[4]  = '{32'hFFFF_FFFB, 5'd0,  1'b0, 16'hFFFB};
        vecs[5]  = '{32'hFFFF_FF00, 5'd4,  1'b0, 16'hFFF0};
        vecs[6]  = '{32'h0001_0000, 5'd1,  1'b0, 16'h7FFF};
        vecs[7]  = '{32'hFFFE_DCBB, 5'd8,  1'b0, 16'hFEDC};
        vecs[8]  = '{32'h8000_0000, 5'd31, 1'b0, 16'hFFFF};
        vecs[9]  = '{32'h8000_0000, 5'd31, 1'b1, 16'h0000};
        vecs[10] = '{32'h0000_7FFF, 5'd0,  1'b0, 16'h7FFF};
        vecs[11] = '{32'hFFFF_8000, 5'd0,  1'b0, 16'h8000};
        vecs[12] = '{32'h0000_8000, 5'd0,  1'b0, 16'h7FFF};
        vecs[13] = '{32'hFFFF_7FFF, 5'd0,  1'b0, 16'h8000};

        repeat (3) tick();
        DR_rst = 1'b0;
        #1;
        chk("rst_vld",   32'(dr_if.DR_out_vld), 32'd0);
        chk("rst_data",  32'($unsigned(dr_if.DR_out_data)), 32'd0);
        chk("rst_level", 32'(DR_level), 32'd0);
        chk("rst_busy",  32'(DR_busy), 32'd0);
        chk("rst_done",  32'(DR_done), 32'd0);
        chk("rst_ovf",   32'(DR_ovf), 32'd0);
        chk("rst_err",   32'(DR_err), 32'd0);

        // Requantisation table: each result must appear at T+2 with an empty FIFO.
        for (int i = 0; i < 14; i++) begin
            DR_cfg_shift = vecs[i].shift;
            DR_cfg_relu  = vecs[i].relu;
            send(vecs[i].data, 1'b0);
            chk("vec_vld",  32'(dr_if.DR_out_vld), 32'd1);
            chk("vec_data", 32'($unsigned(dr_if.DR_out_data)), 32'(vecs[i].exp));
            $display("vec %0d data=0x%08h shift=%0d relu=%0d out=0x%04h", i,
                     vecs[i].data, vecs[i].shift, vecs[i].relu, dr_if.DR_out_data);
            dr_if.DR_out_rdy = 1'b1;
            tick();
            dr_if.DR_out_rdy = 1'b0;
            chk("vec_level", 32'(DR_level), 32'd0);
        end
        DR_cfg_shift = '0;
        DR_cfg_relu  = 1'b0;

        // Overflow: nine results into eight slots, the ninth is dropped.
        do_clear();
        burst(9, 1);
        chk("ovf_level", 32'(DR_level), 32'd8);
        chk("ovf_flag",  32'(DR_ovf), 32'd1);
        dr_if.DR_out_rdy = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            #1;
            chk("ovf_drain_vld",  32'(dr_if.DR_out_vld), 32'd1);
            chk("ovf_drain_data", 32'($unsigned(dr_if.DR_out_data)), 32'(k));
            $display("ovf drain %0d out=%0d", k, dr_if.DR_out_data);
            tick();
        end
        dr_if.DR_out_rdy = 1'b0;
        #1;
        chk("ovf_empty_vld", 32'(dr_if.DR_out_vld), 32'd0);
        chk("ovf_sticky",    32'(DR_ovf), 32'd1);

        // Full FIFO with a push and a pop in the same cycle.
        do_clear();
        chk("clr_ovf", 32'(DR_ovf), 32'd0);
        burst(8, 1);
        chk("full_level", 32'(DR_level), 32'd8);
        DR_calc_en = 1'b1;
        tick();
        DR_calc_en = 1'b0;
        DR_data    = 32'd9;
        dr_if.DR_out_rdy = 1'b1;
        tick();
        dr_if.DR_out_rdy = 1'b0;
        DR_data = '0;
        chk("fp_level", 32'(DR_level), 32'd8);
        chk("fp_ovf",   32'(DR_ovf), 32'd0);
        dr_if.DR_out_rdy = 1'b1;
        for (int k = 2; k <= 9; k++) begin
            #1;
            chk("fp_drain_data", 32'($unsigned(dr_if.DR_out_data)), 32'(k));
            $display("full+pop drain out=%0d", dr_if.DR_out_data);
            tick();
        end
        dr_if.DR_out_rdy = 1'b0;

        // Frame of three with ready toggling.
        do_clear();
        DR_cfg_num = 16'd3;
        send(32'd10, 1'b0);
        send(32'd20, 1'b0);
        send(32'd30, 1'b0);
        chk("frm_level", 32'(DR_level), 32'd3);
        for (int k = 0; k < 5; k++) begin
            dr_if.DR_out_rdy = (k % 2 == 0);
            #1;
            chk("frm_done", 32'(DR_done), (k == 4) ? 32'd1 : 32'd0);
            if (k % 2 == 0)
                chk("frm_data", 32'($unsigned(dr_if.DR_out_data)), 32'(10 * (k / 2 + 1)));
            $display("frame step %0d rdy=%0d done=%0d out=%0d", k,
                     dr_if.DR_out_rdy, DR_done, dr_if.DR_out_data);
            tick();
        end
        dr_if.DR_out_rdy = 1'b0;
        #1;
        chk("frm_done_after", 32'(DR_done), 32'd0);
        chk("frm_busy_after", 32'(DR_busy), 32'd0);
        DR_cfg_num = '0;

        // Store-only data is ignored; store during a result is an error but delivered.
        do_clear();
        DR_store_en = 1'b1;
        DR_data     = 32'd55;
        tick();
        DR_store_en = 1'b0;
        DR_data     = '0;
        chk("store_level", 32'(DR_level), 32'd0);
        chk("store_err",   32'(DR_err), 32'd0);
        send(32'd77, 1'b1);
        chk("coll_err",  32'(DR_err), 32'd1);
        chk("coll_vld",  32'(dr_if.DR_out_vld), 32'd1);
        chk("coll_data", 32'($unsigned(dr_if.DR_out_data)), 32'd77);
        $display("collision out=%0d err=%0d", dr_if.DR_out_data, DR_err);

        // Clear with four queued plus the error flag set.
        burst(4, 100);
        chk("q4_level", 32'(DR_level), 32'd5);
        do_clear();
        chk("clr_level", 32'(DR_level), 32'd0);
        chk("clr_vld",   32'(dr_if.DR_out_vld), 32'd0);
        chk("clr_err",   32'(DR_err), 32'd0);
        chk("clr_data",  32'($unsigned(dr_if.DR_out_data)), 32'd0);

        // Clear wins over a push landing in the same cycle.
        DR_calc_en = 1'b1;
        tick();
        DR_calc_en = 1'b0;
        DR_clr     = 1'b1;
        DR_data    = 32'd5;
        tick();
        DR_clr  = 1'b0;
        DR_data = '0;
        chk("clrpush_level", 32'(DR_level), 32'd0);
        chk("clrpush_busy",  32'(DR_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
